// File: rtl/data_ram_responder.sv
// data_ram_responder: data-port memory responder with a fixed, programmable
// access latency (WAIT_CYCLES) and a one-cycle ready pulse per access.
// Optional DATA_RAM_BYTE_EN adds a 4-bit byte-enable input for writes.
module data_ram_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ram_ena,
    input  logic        data_ram_wea,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DATA_RAM_BYTE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam bit          ZERO_WAIT  = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        wea;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t        state, state_n;
    logic [3:0]    wait_cnt;
    logic          accept, do_access;
    req_t          cur_req, lat_req, acc_req;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   mem [DEPTH];

    // Live request as seen on the ports; without byte enables every write is full-word
    always_comb begin
        cur_req.wea   = data_ram_wea;
        cur_req.addr  = addr;
        cur_req.wdata = wdata;
`ifdef DATA_RAM_BYTE_EN
        cur_req.be    = be;
`else
        cur_req.be    = 4'hF;
`endif
    end

    // With zero wait states the access happens on the accept edge, so use the live request
    assign acc_req = ZERO_WAIT ? cur_req : lat_req;
    assign acc_err = (acc_req.addr[1:0] != 2'b00) || ({1'b0, acc_req.addr} >= ADDR_LIMIT);
    assign acc_idx = acc_req.addr[AW+1:2];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state and access strobes; ena low in WAIT aborts, RESP never accepts
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state)
            S_IDLE: begin
                if (data_ram_ena) begin
                    accept = 1'b1;
                    if (ZERO_WAIT) begin
                        do_access = 1'b1;
                        state_n   = S_RESP;
                    end else begin
                        state_n   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!data_ram_ena) begin
                    state_n = S_IDLE;
                end else if (wait_cnt == 4'd1) begin
                    do_access = 1'b1;
                    state_n   = S_RESP;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Latch the request at acceptance and count down the wait states
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            lat_req  <= '0;
        end else if (accept) begin
            wait_cnt <= WAIT_INIT;
            lat_req  <= cur_req;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Registered response: read-before-write data, error flag, one-cycle ready
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'd0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else if (do_access) begin
            ready <= 1'b1;
            err   <= acc_err;
            rdata <= acc_err ? 32'd0 : mem[acc_idx];
        end else if (state == S_RESP) begin
            ready <= 1'b0;
            err   <= 1'b0;
        end
    end

    // RAM write port, byte-granular; contents survive reset, erroneous writes dropped
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_req.wea && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_req.be[i]) mem[acc_idx][8*i +: 8] <= acc_req.wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed vector table, a
// zero-wait back-to-back run, abort/reset sequences and a randomized run
// against an associative-array memory model.
module tb_data_ram_responder;

    localparam int DEPTH = 1024;
    localparam int W     = 1;
`ifdef DATA_RAM_BYTE_EN
    localparam bit HAS_BE = 1'b1;
`else
    localparam bit HAS_BE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ena, wea;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err;
    logic        ena0, wea0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, err0;
`ifdef DATA_RAM_BYTE_EN
    logic [3:0]  be, be0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    data_ram_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .data_ram_ena(ena), .data_ram_wea(wea),
        .addr(addr), .wdata(wdata),
`ifdef DATA_RAM_BYTE_EN
        .be(be),
`endif
        .rdata(rdata), .ready(ready), .err(err)
    );

    data_ram_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .data_ram_ena(ena0), .data_ram_wea(wea0),
        .addr(addr0), .wdata(wdata0),
`ifdef DATA_RAM_BYTE_EN
        .be(be0),
`endif
        .rdata(rdata0), .ready(ready0), .err(err0)
    );

    typedef struct {
        logic        wea;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          chk;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference memory: error rule, read-before-write, byte merge; unknown words tracked by absence
    function automatic void ref_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] b, output logic [31:0] erd,
                                       output logic eerr, output bit known);
        logic [3:0]  eb = HAS_BE ? b : 4'hF;
        int          idx = int'(a >> 2);
        logic [31:0] nw;
        eerr  = (a % 4 != 0) || (longint'(a) >= longint'(4 * DEPTH));
        erd   = 32'd0;
        known = 1'b1;
        if (eerr) return;
        known = ref_mem.exists(idx);
        if (known) erd = ref_mem[idx];
        if (w) begin
            if (known) begin
                nw = erd;
                for (int i = 0; i < 4; i++) if (eb[i]) nw[8*i +: 8] = d[8*i +: 8];
                ref_mem[idx] = nw;
            end else if (eb == 4'hF) begin
                ref_mem[idx] = d;
            end
        end
    endfunction

    // One full transaction on dut; inputs are scrambled after acceptance to prove latching
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        ena = 1'b1; wea = w; addr = a; wdata = d;
`ifdef DATA_RAM_BYTE_EN
        be = b;
`endif
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready) begin
                lat = n;
                break;
            end
            wea = 1'(~w); addr = $urandom; wdata = $urandom;
`ifdef DATA_RAM_BYTE_EN
            be = 4'($urandom);
`endif
        end
        rd = rdata;
        e  = err;
        ena = 1'b0;
        @(negedge clk);
        check("ready_pulse_width", 32'(ready), 32'd0);
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b, input bit c, input logic [31:0] r, input logic e);
        vec_t v;
        v.wea = w; v.addr = a; v.wdata = d; v.be = b; v.chk = c; v.exp_rd = r; v.exp_err = e;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, erd, a, d;
        logic        e, eerr, w;
        logic [3:0]  b;
        bit          known;
        int          lat, cnt;

        tbl.push_back(mk(1, 32'h10,       32'h12345678, 4'hF, 0, 32'h0,        0));
        tbl.push_back(mk(0, 32'h10,       32'h0,        4'hF, 1, 32'h12345678, 0));
        tbl.push_back(mk(1, 32'h13,       32'hFFFFFFFF, 4'hF, 1, 32'h0,        1));
        tbl.push_back(mk(0, 32'h10,       32'h0,        4'hF, 1, 32'h12345678, 0));
        tbl.push_back(mk(0, 32'h1000,     32'h0,        4'hF, 1, 32'h0,        1));
        tbl.push_back(mk(1, 32'hFFC,      32'hCAFEF00D, 4'hF, 0, 32'h0,        0));
        tbl.push_back(mk(0, 32'hFFC,      32'h0,        4'hF, 1, 32'hCAFEF00D, 0));
        tbl.push_back(mk(1, 32'h20,       32'h55555555, 4'hF, 0, 32'h0,        0));
        tbl.push_back(mk(1, 32'h20,       32'h66666666, 4'hF, 1, 32'h55555555, 0));
        tbl.push_back(mk(1, 32'h30,       32'h11223344, 4'hF, 0, 32'h0,        0));
        tbl.push_back(mk(1, 32'h30,       32'hAABBCCDD, 4'h5, 1, 32'h11223344, 0));
        tbl.push_back(mk(0, 32'h30,       32'h0,        4'hF, 1, HAS_BE ? 32'h11BB33DD : 32'hAABBCCDD, 0));
        tbl.push_back(mk(1, 32'h34,       32'h01020304, 4'hF, 0, 32'h0,        0));
        tbl.push_back(mk(1, 32'h34,       32'h99999999, 4'h0, 1, 32'h01020304, 0));
        tbl.push_back(mk(0, 32'h34,       32'h0,        4'hF, 1, HAS_BE ? 32'h01020304 : 32'h99999999, 0));
        tbl.push_back(mk(0, 32'h80000010, 32'h0,        4'hF, 1, 32'h0,        1));
        tbl.push_back(mk(1, 32'h1010,     32'h77777777, 4'hF, 1, 32'h0,        1));
        tbl.push_back(mk(0, 32'h10,       32'h0,        4'hF, 1, 32'h12345678, 0));

        rst = 1'b1; ena = 1'b0; wea = 1'b0; addr = '0; wdata = '0;
        ena0 = 1'b0; wea0 = 1'b0; addr0 = '0; wdata0 = '0;
`ifdef DATA_RAM_BYTE_EN
        be = 4'hF; be0 = 4'hF;
`endif
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_err",   32'(err), 32'd0);
        check("reset_ready0", 32'(ready0), 32'd0);
        rst = 1'b0;

        // Directed vector table
        foreach (tbl[i]) begin
            ref_access(tbl[i].wea, tbl[i].addr, tbl[i].wdata, tbl[i].be, erd, eerr, known);
            xact(tbl[i].wea, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, e, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
            check($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end

        // Zero wait states, ena held: ready every other cycle, nothing accepted in RESP
        @(negedge clk);
        ena0 = 1'b1; wea0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b_ready%0d", i), 32'(ready0), 32'((i % 2) == 0));
            if (i % 2 == 0) begin
                check($sformatf("b2b_err%0d", i), 32'(err0), 32'd0);
                if (i > 0) check($sformatf("b2b_rdata%0d", i), rdata0, 32'hDEADBEEF);
            end
            if (i == 0) begin
                wea0 = 1'b0; wdata0 = $urandom;
            end
        end
        ena0 = 1'b0;

        // Abort: ena dropped during WAIT of a write
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addr = 32'h20; wdata = 32'hAAAAAAAA;
        @(negedge clk);
        ena = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        check("abort_no_ready", 32'(cnt), 32'd0);
        xact(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
        check("abort_rdata", rd, 32'h66666666);

        // Reset during WAIT of a write
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addr = 32'h20; wdata = 32'hBBBBBBBB;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait_ready", 32'(ready), 32'd0);
        check("rst_wait_err", 32'(err), 32'd0);
        rst = 1'b0; ena = 1'b0;
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        check("rst_wait_no_ready", 32'(cnt), 32'd0);
        xact(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
        check("rst_wait_rdata", rd, 32'h66666666);
        check("rst_wait_latency", 32'(lat), 32'(W + 1));

        // Reset during RESP clears ready
        @(negedge clk);
        ena = 1'b1; wea = 1'b0; addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        check("rst_resp_pre_ready", 32'(ready), 32'd1);
        check("rst_resp_pre_rdata", rdata, 32'h12345678);
        rst = 1'b1; ena = 1'b0;
        @(negedge clk);
        check("rst_resp_ready", 32'(ready), 32'd0);
        check("rst_resp_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Randomized traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            w = 1'($urandom);
            d = $urandom;
            b = 4'($urandom);
            case ($urandom_range(0, 9))
                7:       a = {$urandom_range(0, 31), 2'b00} + 32'($urandom_range(1, 3));
                8:       a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
                9:       a = ($urandom | 32'h80000000) & 32'hFFFFFFFC;
                default: a = 32'({$urandom_range(0, 31), 2'b00});
            endcase
            ref_access(w, a, d, b, erd, eerr, known);
            xact(w, a, d, b, rd, e, lat);
            check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(W + 1));
            check($sformatf("rnd%0d_err", t), 32'(e), 32'(eerr));
            if (known) check($sformatf("rnd%0d_rdata a=%h", t, a), rd, erd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
